// File: rtl/ddr5_phy_freq_pkg.sv
// ============================================================================
// ddr5_phy_freq_pkg: shared FSM states, DFI ratio codes and last-phase helper. Rev 1.0
// ============================================================================
`default_nettype none

package ddr5_phy_freq_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_SWITCH = 2'd2,
      ST_ACK    = 2'd3
   } state_t;

   localparam logic [1:0] RATIO_1TO1 = 2'd0;
   localparam logic [1:0] RATIO_1TO2 = 2'd1;
   localparam logic [1:0] RATIO_1TO4 = 2'd2;
   localparam logic [1:0] RATIO_1TO8 = 2'd3;

   // Index of the final phase in a frame for ratio code r (2^r phases).
   function automatic int unsigned last_phase(input int unsigned ratio);
      return (32'd1 << ratio) - 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ddr5_phy_ratio_fsm.sv
// ============================================================================
// ddr5_phy_ratio_fsm: phase counter plus drain/switch/ack ratio-change FSM. Rev 1.0
// ============================================================================
`default_nettype none

module ddr5_phy_ratio_fsm
   import ddr5_phy_freq_pkg::*;
#(
   parameter int pMAX_PHASES = 4,
   parameter int pPH_W       = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic [pPH_W-1:0] ratio_i,
   input  logic             chg_req_i,
   output logic             chg_ack_o,
   output logic             ratio_err_o,
   output logic             busy_o,
   output logic [pPH_W-1:0] phase_o,
   output logic [pPH_W-1:0] last_o,
   output logic             frame_end_o,
   output logic             switch_o
);

   localparam int              MAX_R    = $clog2(pMAX_PHASES);
   localparam logic [pPH_W-1:0] MAX_CODE = pPH_W'(MAX_R);

   state_t           state_q, state_d;
   logic [pPH_W-1:0] phase_q, phase_d;
   logic [pPH_W-1:0] ratio_q, ratio_d;
   logic             err_q, err_d;
   logic [pPH_W-1:0] last;
   logic             at_last;

   assign last    = pPH_W'(last_phase(32'(ratio_q)));
   assign at_last = (phase_q == last);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_RUN;
         phase_q <= '0;
         ratio_q <= pPH_W'(RATIO_1TO1);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ratio_q <= ratio_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      ratio_d = ratio_q;
      err_d   = err_q;
      if (enable_i) begin
         phase_d = at_last ? '0 : phase_q + 1'b1;
         case (state_q)
            ST_RUN:   if (chg_req_i) state_d = ST_DRAIN;
            // Only leave once the in-flight frame has been fully emitted.
            ST_DRAIN: if (at_last) state_d = ST_SWITCH;
            ST_SWITCH: begin
               phase_d = '0;
               ratio_d = (ratio_i > MAX_CODE) ? MAX_CODE : ratio_i;
               if (ratio_i > MAX_CODE) err_d = 1'b1;
               state_d = ST_ACK;
            end
            ST_ACK:   state_d = ST_RUN;
            default:  state_d = ST_RUN;
         endcase
      end
   end

   assign chg_ack_o   = enable_i & (state_q == ST_ACK);
   assign ratio_err_o = err_q;
   assign busy_o      = (state_q == ST_DRAIN) | (state_q == ST_SWITCH);
   assign phase_o     = phase_q;
   assign last_o      = last;
   assign switch_o    = (state_q == ST_SWITCH);
   assign frame_end_o = enable_i & at_last & (state_q != ST_SWITCH);

endmodule

`default_nettype wire

// File: rtl/ddr5_phy_freq_ratio_gen2.sv
// ============================================================================
// ddr5_phy_freq_ratio_gen2: parametric DFI ratio TX serialiser / RX deserialiser. Rev 1.0
// ============================================================================
`default_nettype none

module ddr5_phy_freq_ratio_gen2
   import ddr5_phy_freq_pkg::*;
#(
   parameter int               pMAX_PHASES = 4,
   parameter int               pPH_W       = 2,
   parameter int               pTX_W       = 40,
   parameter int               pRX_W       = 18,
   parameter logic [pRX_W-1:0] pRX_IDLE    = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         enable_i,
   input  logic [pPH_W-1:0]             ratio_i,
   input  logic                         chg_req_i,
   output logic                         chg_ack_o,
   output logic                         ratio_err_o,
   output logic                         busy_o,
   input  logic [pMAX_PHASES*pTX_W-1:0] tx_phase_i,
   output logic                         tx_load_o,
   output logic [pTX_W-1:0]             tx_data_o,
   input  logic [pRX_W-1:0]             rx_data_i,
   output logic [pMAX_PHASES*pRX_W-1:0] rx_phase_o,
   output logic                         rx_valid_o,
   output logic [pPH_W-1:0]             phase_o
);

   logic [pPH_W-1:0] phase;
   logic [pPH_W-1:0] last;
   logic             frame_end;
   logic             in_switch;
   logic             advance;
   logic             rx_valid_q;
   logic [pTX_W-1:0] tx_slice [pMAX_PHASES];
   logic [pRX_W-1:0] slot_q   [pMAX_PHASES];
   logic [pRX_W-1:0] frame_q  [pMAX_PHASES];

   ddr5_phy_ratio_fsm #(
      .pMAX_PHASES (pMAX_PHASES),
      .pPH_W       (pPH_W)
   ) u_fsm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .enable_i    (enable_i),
      .ratio_i     (ratio_i),
      .chg_req_i   (chg_req_i),
      .chg_ack_o   (chg_ack_o),
      .ratio_err_o (ratio_err_o),
      .busy_o      (busy_o),
      .phase_o     (phase),
      .last_o      (last),
      .frame_end_o (frame_end),
      .switch_o    (in_switch)
   );

   assign advance = enable_i & ~in_switch;

   generate
      for (genvar k = 0; k < pMAX_PHASES; k++) begin : g_lane
         assign tx_slice[k]                  = tx_phase_i[k*pTX_W +: pTX_W];
         assign rx_phase_o[k*pRX_W +: pRX_W] = frame_q[k];
      end
   endgenerate

   // TX output holds through SWITCH so the line never glitches mid-change.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)       tx_data_o <= '0;
      else if (advance) tx_data_o <= tx_slice[phase];
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)        rx_valid_q <= 1'b0;
      else if (enable_i) rx_valid_q <= frame_end;
   end

   // The final beat bypasses its slot so the frame is published one cycle after it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < pMAX_PHASES; k++) begin
            slot_q[k]  <= pRX_IDLE;
            frame_q[k] <= pRX_IDLE;
         end
      end else if (advance) begin
         for (int k = 0; k < pMAX_PHASES; k++) begin
            if (phase == pPH_W'(k))
               slot_q[k] <= rx_data_i;
            else if (frame_end && (pPH_W'(k) > last))
               slot_q[k] <= pRX_IDLE;
            if (frame_end) begin
               if (phase == pPH_W'(k))      frame_q[k] <= rx_data_i;
               else if (pPH_W'(k) > last)   frame_q[k] <= pRX_IDLE;
               else                         frame_q[k] <= slot_q[k];
            end
         end
      end
   end

   assign rx_valid_o = enable_i & rx_valid_q;
   assign tx_load_o  = rst_i & enable_i & (phase == '0) & ~in_switch;
   assign phase_o    = phase;

endmodule

`default_nettype wire

// File: tb/tb_ddr5_phy_freq_ratio_gen2.sv
// ============================================================================
// tb_ddr5_phy_freq_ratio_gen2: directed table-driven bench for the gen2 ratio block. Rev 1.0
// ============================================================================
`default_nettype none

module tb_ddr5_phy_freq_ratio_gen2;

   localparam int               NPH  = 4;
   localparam int               PHW  = 2;
   localparam int               TXW  = 40;
   localparam int               RXW  = 18;
   localparam logic [RXW-1:0]   IDLE = 18'h20000;
   localparam int               I    = 'h20000;
   localparam int               NV   = 36;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 en = 1'b0;
   logic                 req = 1'b0;
   logic [PHW-1:0]       ratio = '0;
   logic [NPH*TXW-1:0]   tx_phase;
   logic [RXW-1:0]       rx = '0;
   logic                 ack, err, busy, load, valid;
   logic [TXW-1:0]       tx;
   logic [NPH*RXW-1:0]   rxp_out;
   logic [PHW-1:0]       phase;

   int total = 0;
   int bad   = 0;
   int row   = -1;
   logic [TXW-1:0] slc [4];

   typedef struct {
      logic        en, req;
      logic [1:0]  ratio;
      logic [17:0] rx;
      logic [1:0]  ph;
      int          tx;
      logic        load, v, a, b, e, crx;
      logic [71:0] rxp;
   } vec_t;

   vec_t tv [NV];

   always #5 clk = ~clk;

   ddr5_phy_freq_ratio_gen2 #(
      .pMAX_PHASES (NPH),
      .pPH_W       (PHW),
      .pTX_W       (TXW),
      .pRX_W       (RXW),
      .pRX_IDLE    (IDLE)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .enable_i    (en),
      .ratio_i     (ratio),
      .chg_req_i   (req),
      .chg_ack_o   (ack),
      .ratio_err_o (err),
      .busy_o      (busy),
      .tx_phase_i  (tx_phase),
      .tx_load_o   (load),
      .tx_data_o   (tx),
      .rx_data_i   (rx),
      .rx_phase_o  (rxp_out),
      .rx_valid_o  (valid),
      .phase_o     (phase)
   );

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL row=%0d %s: got %h want %h", row, name, act, exp);
      end
   endtask

   function automatic logic [71:0] rxp(input int s3, input int s2, input int s1, input int s0);
      return {18'(s3), 18'(s2), 18'(s1), 18'(s0)};
   endfunction

   function automatic logic [TXW-1:0] txv(input int code);
      return (code == 0) ? '0 : slc[code-1];
   endfunction

   function automatic vec_t mk(input bit e_n, input bit rq, input int rt, input int d,
                               input int ph, input int t, input bit ld, input bit v,
                               input bit a, input bit b, input bit e, input bit crx,
                               input logic [71:0] rp);
      vec_t r;
      r.en = e_n;  r.req = rq;  r.ratio = 2'(rt);  r.rx = 18'(d);
      r.ph = 2'(ph); r.tx = t;  r.load = ld;       r.v = v;
      r.a = a;     r.b = b;     r.e = e;           r.crx = crx;
      r.rxp = rp;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      slc[0] = 40'h11_1111_1111;
      slc[1] = 40'h22_2222_2222;
      slc[2] = 40'h33_3333_3333;
      slc[3] = 40'h44_4444_4444;
      tx_phase = {slc[3], slc[2], slc[1], slc[0]};

      //           en rq rt  rx   ph tx ld v  a  b  e  crx rxp
      // 1:1 after reset
      tv[0]  = mk(1, 0, 0,  5,   0, 0, 1, 0, 0, 0, 0, 1, rxp(I, I, I, I));
      tv[1]  = mk(1, 0, 0,  6,   0, 1, 1, 1, 0, 0, 0, 1, rxp(I, I, I, 5));
      tv[2]  = mk(1, 0, 0,  7,   0, 1, 1, 1, 0, 0, 0, 1, rxp(I, I, I, 6));
      // request ratio 2 from 1:1
      tv[3]  = mk(1, 1, 2,  8,   0, 1, 1, 1, 0, 0, 0, 1, rxp(I, I, I, 7));
      tv[4]  = mk(1, 1, 2,  9,   0, 1, 1, 1, 0, 1, 0, 1, rxp(I, I, I, 8));
      tv[5]  = mk(1, 1, 2, 10,   0, 1, 0, 1, 0, 1, 0, 1, rxp(I, I, I, 9));
      tv[6]  = mk(1, 1, 2,  1,   0, 1, 1, 0, 1, 0, 0, 1, rxp(I, I, I, 9));
      tv[7]  = mk(1, 0, 2,  2,   1, 1, 0, 0, 0, 0, 0, 0, '0);
      tv[8]  = mk(1, 0, 2,  3,   2, 2, 0, 0, 0, 0, 0, 0, '0);
      tv[9]  = mk(1, 0, 2,  4,   3, 3, 0, 0, 0, 0, 0, 1, rxp(I, I, I, 9));
      tv[10] = mk(1, 0, 2, 11,   0, 4, 1, 1, 0, 0, 0, 1, rxp(4, 3, 2, 1));
      // request ratio 1 at phase 1 of a 4-phase frame
      tv[11] = mk(1, 1, 1, 12,   1, 1, 0, 0, 0, 0, 0, 0, '0);
      tv[12] = mk(1, 1, 1, 13,   2, 2, 0, 0, 0, 1, 0, 0, '0);
      tv[13] = mk(1, 1, 1, 14,   3, 3, 0, 0, 0, 1, 0, 0, '0);
      tv[14] = mk(1, 1, 1, 15,   0, 4, 0, 1, 0, 1, 0, 1, rxp(14, 13, 12, 11));
      tv[15] = mk(1, 1, 1, 21,   0, 4, 1, 0, 1, 0, 0, 0, '0);
      tv[16] = mk(1, 0, 1, 22,   1, 1, 0, 0, 0, 0, 0, 0, '0);
      tv[17] = mk(1, 0, 1, 23,   0, 2, 1, 1, 0, 0, 0, 1, rxp(I, I, 22, 21));
      tv[18] = mk(1, 0, 1, 24,   1, 1, 0, 0, 0, 0, 0, 0, '0);
      // out-of-range code 3: clamp to 4 phases, sticky error
      tv[19] = mk(1, 1, 3, 25,   0, 2, 1, 1, 0, 0, 0, 1, rxp(I, I, 24, 23));
      tv[20] = mk(1, 1, 3, 26,   1, 1, 0, 0, 0, 1, 0, 0, '0);
      tv[21] = mk(1, 1, 3, 27,   0, 2, 0, 1, 0, 1, 0, 1, rxp(I, I, 26, 25));
      tv[22] = mk(1, 1, 3, 31,   0, 2, 1, 0, 1, 0, 1, 0, '0);
      tv[23] = mk(1, 0, 0, 32,   1, 1, 0, 0, 0, 0, 1, 0, '0);
      tv[24] = mk(1, 0, 0, 33,   2, 2, 0, 0, 0, 0, 1, 0, '0);
      tv[25] = mk(1, 0, 0, 34,   3, 3, 0, 0, 0, 0, 1, 0, '0);
      tv[26] = mk(1, 0, 0, 35,   0, 4, 1, 1, 0, 0, 1, 1, rxp(34, 33, 32, 31));
      tv[27] = mk(1, 0, 0, 36,   1, 1, 0, 0, 0, 0, 1, 0, '0);
      // enable low for 5 cycles mid-frame with garbage on rx
      for (int k = 28; k < 33; k++)
         tv[k] = mk(0, 0, 0, 'h3FFFF, 2, 2, 0, 0, 0, 0, 1, 1, rxp(34, 33, 32, 31));
      tv[33] = mk(1, 0, 0, 37,   2, 2, 0, 0, 0, 0, 1, 0, '0);
      tv[34] = mk(1, 0, 0, 38,   3, 3, 0, 0, 0, 0, 1, 0, '0);
      tv[35] = mk(1, 0, 0, 39,   0, 4, 1, 1, 0, 0, 1, 1, rxp(38, 37, 36, 35));

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_phase", 72'(phase), 72'(0));
      chk("rst_tx", 72'(tx), 72'(0));
      chk("rst_rxp", 72'(rxp_out), rxp(I, I, I, I));
      chk("rst_valid", 72'(valid), 72'(0));
      chk("rst_ack", 72'(ack), 72'(0));
      chk("rst_err", 72'(err), 72'(0));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         row   = i;
         en    = tv[i].en;
         req   = tv[i].req;
         ratio = tv[i].ratio;
         rx    = tv[i].rx;
         #4;
         chk("phase", 72'(phase), 72'(tv[i].ph));
         chk("tx_data", 72'(tx), 72'(txv(tv[i].tx)));
         chk("tx_load", 72'(load), 72'(tv[i].load));
         chk("rx_valid", 72'(valid), 72'(tv[i].v));
         chk("chg_ack", 72'(ack), 72'(tv[i].a));
         chk("busy", 72'(busy), 72'(tv[i].b));
         chk("ratio_err", 72'(err), 72'(tv[i].e));
         if (tv[i].crx) chk("rx_phase", 72'(rxp_out), tv[i].rxp);
         @(posedge clk);
         #1;
      end

      // reset asserted while draining a ratio change
      row   = 100;
      en    = 1'b1;
      req   = 1'b1;
      ratio = 2'd1;
      @(posedge clk);
      #1;
      chk("drain_busy", 72'(busy), 72'(1));
      chk("drain_phase", 72'(phase), 72'(2));
      #2;
      rst = 1'b0;
      #1;
      chk("arst_phase", 72'(phase), 72'(0));
      chk("arst_tx", 72'(tx), 72'(0));
      chk("arst_rxp", 72'(rxp_out), rxp(I, I, I, I));
      chk("arst_valid", 72'(valid), 72'(0));
      chk("arst_busy", 72'(busy), 72'(0));
      chk("arst_load", 72'(load), 72'(0));
      chk("arst_err", 72'(err), 72'(0));
      req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         row = 101 + i;
         rx  = 18'(50 + i);
         #4;
         chk("post_phase", 72'(phase), 72'(0));
         chk("post_tx", 72'(tx), 72'(slc[0]));
         chk("post_valid", 72'(valid), 72'(1));
         chk("post_ack", 72'(ack), 72'(0));
         chk("post_busy", 72'(busy), 72'(0));
         if (i > 0) chk("post_rxp", 72'(rxp_out), rxp(I, I, I, 50 + i - 1));
         @(posedge clk);
         #1;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
